cpu_tia_clock_sequencer: RTL
============================

Name: cpu_tia_clock_sequencer

Overview:
- Generates the CPU, TIA and PIA clock-enable strobes from the single VGA pixel clock.
- Phase-locks the enables to the VGA scanline: 2 VGA lines = 1 TIA line of 228 color clocks = 76 CPU cycles.
- Optional frame lock: when TIA starts a frame early, it freezes the emulated machine until the next VGA vsync, then restarts it aligned to a line start.
- Sits between the VGA sync generator and the 6502/TIA/PIA; drives their enable/RDY inputs.

Parameters:
- DIV, 21, pixel clocks per CPU cycle (phase counter modulus).
- CPU_PHASE, 0, phase at which cpu_enable and pia_enable fire.
- TIA_PHASE0, 1, first TIA color-clock phase.
- TIA_PHASE1, 8, second TIA color-clock phase.
- TIA_PHASE2, 15, third TIA color-clock phase.
- LINE_LEN, 800, VGA pixels per line.
- LINE_SKIP, 2, trailing pixels per line with all enables suppressed. Resync point RS = LINE_LEN-LINE_SKIP.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- vga_hpos  in  10  current VGA x position
- vga_vsync  in  1  VGA vsync level; rising edge used
- tia_vsync  in  1  TIA VSYNC register level; rising edge used
- stall_cpu  in  1  TIA WSYNC stall
- frame_lock_en  in  1  enables frame-lock hold
- cpu_enable  out  1  CPU-cycle strobe (gates bus logic)
- cpu_rdy  out  1  6502 RDY = cpu_enable & ~stall_cpu
- tia_enable  out  1  TIA color-clock strobe
- pia_enable  out  1  PIA timer strobe
- phase  out  5  current phase counter value
- frame_hold  out  1  high while the machine is frozen (HOLD or ALIGN)
- cpu_cycles_last  out  8  CPU strobes counted in the previous VGA line

Behaviour:
- Reset (async, rst_n=0):
  - phase=0, state=RUN, edge-detect registers=0, line counter=0, cpu_cycles_last=0.
  - All strobes are low while in reset.
- Phase counter:
  - Registered.
  - If vga_hpos>=RS: next phase=0.
  - Else if phase==DIV-1: next phase=0.
  - Else: phase+1.
  - Result: phase is 0 during vga_hpos=0, and phase = hpos mod DIV for hpos<RS.
  - Counter runs in every state; it is never frozen.
- Skip window: any cycle with vga_hpos>=RS, or state!=RUN, forces cpu_enable, tia_enable and pia_enable low.
- Strobe decode (combinational from registered phase/state; single-cycle pulses):
  - cpu_enable = pia_enable = (phase==CPU_PHASE).
  - tia_enable = (phase ∈ {TIA_PHASE0, TIA_PHASE1, TIA_PHASE2}).
  - Both subject to the skip-window masking above.
- cpu_rdy = cpu_enable & ~stall_cpu. stall_cpu never affects tia_enable or pia_enable.
- Edge detect: tia_vsync and vga_vsync are each registered once. rise = cur & ~prev.
- FSM states: RUN, HOLD, ALIGN.
  - RUN → HOLD: tia_vsync rise & frame_lock_en & no vga_vsync rise in the same cycle.
    - Simultaneous rises mean the frames are already aligned, so the FSM stays in RUN.
  - HOLD → ALIGN: vga_vsync rise, or frame_lock_en=0.
  - ALIGN → RUN: on the cycle where vga_hpos==LINE_LEN-1. The first RUN cycle is hpos=0 with phase=0.
  - frame_hold = (state!=RUN), registered alongside state.
- Line cycle counter:
  - Increments on each cpu_enable, saturating at 255.
  - At vga_hpos==LINE_LEN-1: cpu_cycles_last ← count (including a strobe in that same cycle, none in practice); count ← 0.
- Nominal figures (defaults):
  - 38 cpu_enable and 114 tia_enable strobes per VGA line.
  - cpu_cycles_last=38 in steady RUN; 0 for lines spent fully in HOLD.
- Mid-operation reset: immediate return to reset values; the first strobe follows the normal phase rule after release.

Test Plan:
- Free run, frame_lock_en=0, hpos sweeping 0..799:
  - cpu_enable at hpos 0,21,…,777 (38 pulses); tia_enable at hpos 1,8,15,22,… (114 pulses).
  - No strobes at hpos 798,799; cpu_cycles_last=38 after the line.
- stall_cpu=1 for hpos 0..100: cpu_enable still pulses at 0,21,42,63,84; cpu_rdy stays low; tia_enable unchanged.
- frame_lock_en=1, tia_vsync rises at hpos 300 on line 10:
  - frame_hold rises next cycle; no strobes thereafter.
  - vga_vsync rises → ALIGN; RUN resumes at hpos=0 with cpu_enable asserted that cycle; the next line reports cpu_cycles_last=38.
- tia_vsync and vga_vsync rise in the same cycle with frame_lock_en=1: state stays RUN, frame_hold stays 0.
- In HOLD, drop frame_lock_en: ALIGN, then RUN at the next hpos=0. A full held line reports cpu_cycles_last=0.
- Assert rst_n=0 at hpos 400 mid-HOLD: all outputs go to 0 asynchronously, state=RUN. After release, strobes resume per the phase rule.

Source files
------------

// File: rtl/cpu_tia_clock_sequencer.sv
// Derives CPU/TIA/PIA clock-enable strobes from the VGA pixel clock, phase-locked to the
// scanline, with an optional frame lock that freezes the machine until the next VGA vsync.
//
// state | meaning
// RUN   | strobes generated from phase counter
// HOLD  | TIA frame started early; machine frozen, waiting for VGA vsync
// ALIGN | waiting for the last pixel of the line to restart on a line start
module cpu_tia_clock_sequencer #(
  parameter int DIV        = 21,
  parameter int CPU_PHASE  = 0,
  parameter int TIA_PHASE0 = 1,
  parameter int TIA_PHASE1 = 8,
  parameter int TIA_PHASE2 = 15,
  parameter int LINE_LEN   = 800,
  parameter int LINE_SKIP  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] vga_hpos,
  input  logic       vga_vsync,
  input  logic       tia_vsync,
  input  logic       stall_cpu,
  input  logic       frame_lock_en,
  output logic       cpu_enable,
  output logic       cpu_rdy,
  output logic       tia_enable,
  output logic       pia_enable,
  output logic [4:0] phase,
  output logic       frame_hold,
  output logic [7:0] cpu_cycles_last
);

  localparam logic [9:0] RS        = 10'(LINE_LEN - LINE_SKIP);
  localparam logic [9:0] LINE_LAST = 10'(LINE_LEN - 1);
  localparam logic [4:0] PH_LAST   = 5'(DIV - 1);
  localparam logic [4:0] PH_CPU    = 5'(CPU_PHASE);
  localparam logic [4:0] PH_TIA0   = 5'(TIA_PHASE0);
  localparam logic [4:0] PH_TIA1   = 5'(TIA_PHASE1);
  localparam logic [4:0] PH_TIA2   = 5'(TIA_PHASE2);

  typedef enum logic [1:0] {ST_RUN, ST_HOLD, ST_ALIGN} state_t;

  state_t     state;
  logic       tia_vsync_q;
  logic       vga_vsync_q;
  logic [7:0] cycle_cnt;
  logic       tia_rise;
  logic       vga_rise;
  logic       suppress;
  logic       line_end;

  assign tia_rise = tia_vsync & ~tia_vsync_q;
  assign vga_rise = vga_vsync & ~vga_vsync_q;
  assign line_end = (vga_hpos == LINE_LAST);

  // rst_n is folded in so the strobes drop immediately on an asynchronous reset
  // even though phase==0 would otherwise decode as a CPU cycle.
  assign suppress   = (vga_hpos >= RS) || (state != ST_RUN) || !rst_n;
  assign cpu_enable = !suppress && (phase == PH_CPU);
  assign pia_enable = cpu_enable;
  assign tia_enable = !suppress &&
                      ((phase == PH_TIA0) || (phase == PH_TIA1) || (phase == PH_TIA2));
  assign cpu_rdy    = cpu_enable & ~stall_cpu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase       <= '0;
      tia_vsync_q <= 1'b0;
      vga_vsync_q <= 1'b0;
    end else begin
      tia_vsync_q <= tia_vsync;
      vga_vsync_q <= vga_vsync;
      if (vga_hpos >= RS || phase == PH_LAST) phase <= '0;
      else                                    phase <= phase + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      frame_hold <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          // simultaneous rises mean the frames are already aligned
          if (tia_rise && frame_lock_en && !vga_rise) begin
            state      <= ST_HOLD;
            frame_hold <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (vga_rise || !frame_lock_en) state <= ST_ALIGN;
        end
        ST_ALIGN: begin
          if (line_end) begin
            state      <= ST_RUN;
            frame_hold <= 1'b0;
          end
        end
        default: begin
          state      <= ST_RUN;
          frame_hold <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt       <= '0;
      cpu_cycles_last <= '0;
    end else if (line_end) begin
      cpu_cycles_last <= (cpu_enable && cycle_cnt != 8'hff) ? cycle_cnt + 8'd1 : cycle_cnt;
      cycle_cnt       <= '0;
    end else if (cpu_enable && cycle_cnt != 8'hff) begin
      cycle_cnt <= cycle_cnt + 8'd1;
    end
  end

endmodule
